// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit.
// Signed and unsigned operations use the same datapath. Signed operands are
// reduced to magnitudes when the request is accepted. The signs are put back
// in the final FIX cycle.
//   multu/mult : WIDTH shift-add steps, giving the full 2*WIDTH-bit product in {hi, lo}.
//   divu/div   : WIDTH restoring shift-subtract steps, giving quotient in lo and remainder in hi.
//   A divide by zero skips the iterations and reports hi=a, lo=all ones.
// Ports:
//   clk, reset        - clock; asynchronous active-high reset
//   start, op, a, b   - request, operation (00 multu, 01 mult, 10 divu, 11 div) and operands
//   busy              - high while an operation is in flight
//   done              - one-cycle pulse when hi/lo/div_by_zero carry a new result
//   hi, lo            - result (product halves, or remainder/quotient)
//   div_by_zero       - qualifies the last completed divide
module mul_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);
    typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

    localparam logic [WIDTH-1:0] Iters  = WIDTH'(WIDTH);
    localparam logic [WIDTH-1:0] CntOne = WIDTH'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic             is_div_q, is_div_d;
    logic             neg_lo_q, neg_lo_d;
    logic             neg_hi_q, neg_hi_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             dbz_q, dbz_d;
    logic             done_q, done_d;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     add_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] product, product_neg;

    assign a_neg = op[0] & a[WIDTH-1];
    assign b_neg = op[0] & b[WIDTH-1];
    // The magnitude of the most-negative value is 2^(WIDTH-1), which still fits unsigned.
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    // Multiply: {acc_hi, acc_lo} is the partial product, and acc_lo shifts out multiplier bits.
    // Divide: acc_hi is the partial remainder, and acc_lo shifts dividend bits out and quotient bits in.
    assign add_sum     = {1'b0, acc_hi_q} + {1'b0, opb_q};
    assign div_shift   = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign div_diff    = div_shift - {1'b0, opb_q};
    assign product     = {acc_hi_q, acc_lo_q};
    assign product_neg = -product;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        opb_d    = opb_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        dz_d     = dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dbz_d    = dbz_q;
        done_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    is_div_d = op[1];
                    cnt_d    = Iters;
                    acc_hi_d = '0;
                    acc_lo_d = a_mag;
                    opb_d    = b_mag;
                    neg_lo_d = a_neg ^ b_neg;  // product or quotient sign
                    neg_hi_d = a_neg;          // remainder follows the dividend
                    if (op[1] && (b == '0)) begin
                        dz_d     = 1'b1;
                        acc_hi_d = a;
                        state_d  = StFix;
                    end else begin
                        dz_d    = 1'b0;
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (!is_div_q) begin
                    if (acc_lo_q[0]) begin
                        {acc_hi_d, acc_lo_d} = {add_sum, acc_lo_q[WIDTH-1:1]};
                    end else begin
                        {acc_hi_d, acc_lo_d} = {1'b0, acc_hi_q, acc_lo_q[WIDTH-1:1]};
                    end
                end else if (!div_diff[WIDTH]) begin
                    acc_hi_d = div_diff[WIDTH-1:0];
                    acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_hi_d = div_shift[WIDTH-1:0];
                    acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - CntOne;
                if (cnt_q == CntOne) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                state_d = StIdle;
                done_d  = 1'b1;
                if (dz_q) begin
                    hi_d  = acc_hi_q;
                    lo_d  = '1;
                    dbz_d = 1'b1;
                end else if (!is_div_q) begin
                    {hi_d, lo_d} = neg_lo_q ? product_neg : product;
                    dbz_d        = 1'b0;
                end else begin
                    lo_d  = neg_lo_q ? -acc_lo_q : acc_lo_q;
                    hi_d  = neg_hi_q ? -acc_hi_q : acc_hi_q;
                    dbz_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opb_q    <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            dbz_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            opb_q    <= opb_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            dbz_q    <= dbz_d;
            done_q   <= done_d;
        end
    end

    assign busy        = (state_q != StIdle);
    assign done        = done_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Testbench for mul_div_unit with WIDTH=32.
// The stimulus process pushes the expected result and its done cycle into a queue for each
// accepted request. A forked monitor pops the queue on every done pulse and compares.
// Between done pulses the monitor also checks that the outputs hold their values.
module tb_mul_div_unit;
    localparam int W = 32;

    logic         clk   = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op    = 2'b00;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] hi, lo;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          cyc;
    } exp_t;

    exp_t sbq[$];

    mul_div_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: plain 64-bit arithmetic. SystemVerilog signed division truncates
    // toward zero, and the remainder takes the dividend's sign.
    function automatic exp_t model(input logic [1:0] o, input logic [31:0] x,
                                   input logic [31:0] y);
        exp_t        e;
        longint      sx, sy, p;
        logic [63:0] u;
        e.hi  = '0;
        e.lo  = '0;
        e.dbz = 1'b0;
        e.cyc = 0;
        sx    = $signed(x);
        sy    = $signed(y);
        case (o)
            2'b00: begin
                u = {32'b0, x} * {32'b0, y};
                {e.hi, e.lo} = u;
            end
            2'b01: begin
                p = sx * sy;
                {e.hi, e.lo} = p;
            end
            default: begin
                if (y == 0) begin
                    e.hi  = x;
                    e.lo  = '1;
                    e.dbz = 1'b1;
                end else if (o == 2'b10) begin
                    e.lo = x / y;
                    e.hi = x % y;
                end else begin
                    e.lo = 32'(sx / sy);
                    e.hi = 32'(sx % sy);
                end
            end
        endcase
        return e;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h0000_0000;
            3:       return 32'h0000_0001;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic monitor();
        exp_t        e;
        logic [31:0] lh = '0;
        logic [31:0] ll = '0;
        logic        ld = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                sbq.delete();
                lh = '0;
                ll = '0;
                ld = 1'b0;
            end else if (done) begin
                chk("busy_low_in_done", busy, 0);
                if (sbq.size() == 0) begin
                    chk("done_without_request", done, 0);
                    lh = hi;
                    ll = lo;
                    ld = div_by_zero;
                end else begin
                    e = sbq.pop_front();
                    chk("hi", hi, e.hi);
                    chk("lo", lo, e.lo);
                    chk("div_by_zero", div_by_zero, e.dbz);
                    chk("done_cycle", cyc, e.cyc);
                    lh = e.hi;
                    ll = e.lo;
                    ld = e.dbz;
                end
            end else begin
                chk("hold_hi", hi, lh);
                chk("hold_lo", lo, ll);
                chk("hold_dbz", div_by_zero, ld);
            end
        end
    endtask

    // Called at a negedge. It waits for the unit to be free, then drives the request.
    // It returns one negedge after the accepting edge, with start still high.
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        int   n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", busy, 0);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        e     = model(o, x, y);
        e.cyc = cyc + 1 + ((o[1] && (y == 0)) ? 1 : W + 1);
        sbq.push_back(e);
        @(negedge clk);
        chk("busy_after_accept", busy, 1);
    endtask

    task automatic finish_op();
        int n = 0;
        start = 1'b0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("op_timeout", busy, 0);
    endtask

    initial begin
        int n;
        fork
            monitor();
        join_none

        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_hi", hi, 0);
        chk("reset_lo", lo, 0);
        chk("reset_dbz", div_by_zero, 0);
        #2 reset = 1'b0;
        @(negedge clk);

        issue(2'b01, 32'hFFFF_FFFF, 32'h0000_0003);
        finish_op();
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        finish_op();
        issue(2'b11, 32'hFFFF_FFF9, 32'h0000_0002);
        finish_op();
        // Divide by zero followed back-to-back by a normal divide.
        issue(2'b10, 32'h1234_5678, 32'h0000_0000);
        issue(2'b10, 32'd10, 32'd3);
        finish_op();
        issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
        finish_op();
        issue(2'b01, 32'h8000_0000, 32'h8000_0000);
        finish_op();

        // A new request while busy must not disturb the running multiply.
        issue(2'b01, 32'd5, 32'd7);
        repeat (9) @(negedge clk);
        op = 2'b10;
        a  = 32'h0000_DEAD;
        b  = 32'd3;
        repeat (5) @(negedge clk);
        finish_op();

        // Reset in the middle of an operation: outputs clear at once and no done pulse follows.
        issue(2'b00, $urandom, $urandom);
        repeat (19) @(negedge clk);
        #2 reset = 1'b1;
        start = 1'b0;
        #1;
        chk("midop_reset_busy", busy, 0);
        chk("midop_reset_done", done, 0);
        chk("midop_reset_hi", hi, 0);
        chk("midop_reset_lo", lo, 0);
        chk("midop_reset_dbz", div_by_zero, 0);
        @(negedge clk);
        #2 reset = 1'b0;
        repeat (40) @(negedge clk);
        issue(2'b10, 32'd100, 32'd7);
        finish_op();

        // Random mixed operations with start held high continuously.
        for (int i = 0; i < 300; i++) begin
            issue(2'($urandom_range(0, 3)), pick(), pick());
        end
        finish_op();

        n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("queue_drained", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
